// File: rtl/wave_capture_pkg.sv
// Shared types for the wave_capture triggered capture buffer.
package wave_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        READ
    } cap_state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module wave_capture_ram #(
    parameter int unsigned WIDTH      = 48,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/wave_capture.sv
// Multi-channel triggered capture buffer: ring record with pre-trigger window,
// level/forced trigger, and oldest-first valid/ready readout.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned CH         = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       LINK       = ""
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_en,
  input  logic [CH*DATA_WIDTH-1:0]               i_data,
  input  logic                                   i_arm,
  input  logic                                   i_abort,
  input  logic                                   i_force,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] i_trig_ch,
  input  logic                                   i_trig_edge,
  input  logic [DATA_WIDTH-1:0]                  i_trig_level,
  input  logic [ADDR_WIDTH-1:0]                  i_pre_len,
  output logic                                   o_busy,
  output logic                                   o_triggered,
  output logic                                   o_rd_valid,
  input  logic                                   i_rd_ready,
  output logic [CH*DATA_WIDTH-1:0]               o_rd_data,
  output logic                                   o_rd_last
);

  localparam int unsigned W   = CH * DATA_WIDTH;
  localparam int unsigned TCW = (CH > 1) ? $clog2(CH) : 1;

  cap_state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]        ptr, cnt, pre_len_q;
  logic                         prev_valid, force_pend, triggered;
  logic signed [DATA_WIDTH-1:0] prev, cur, level;
  logic                         rise_hit, fall_hit, trig_fire, we;
  logic                         issue, pop, out_free;
  logic [1:0]                   occ;
  logic [ADDR_WIDTH:0]          rd_issued;
  logic                         rd_pend, pend_last;
  logic                         rd_valid, rd_last, sk_valid, sk_last;
  logic [W-1:0]                 rd_data, sk_data, ram_q;

  assign level = i_trig_level;

  always_comb begin
    cur = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (i_trig_ch == TCW'(c)) cur = i_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rise_hit = prev_valid && (prev < level) && (cur >= level);
  assign fall_hit = prev_valid && (prev > level) && (cur <= level);

  always_comb begin
    trig_fire = 1'b0;
    if (state == WAIT_TRIG && i_en) begin
      trig_fire = force_pend || i_force;
      case (i_trig_edge)
        EDGE_RISE: if (rise_hit) trig_fire = 1'b1;
        EDGE_FALL: if (fall_hit) trig_fire = 1'b1;
        default: ;
      endcase
    end
  end

  assign we = i_en && (state == PRE || state == WAIT_TRIG || state == POST);

  // Two output slots (data + skid) shared with the in-flight RAM read.
  assign occ      = 2'(rd_valid) + 2'(sk_valid) + 2'(rd_pend);
  assign pop      = rd_valid && i_rd_ready;
  assign out_free = !rd_valid || i_rd_ready;
  assign issue    = (state == READ) && !rd_issued[ADDR_WIDTH] && ((occ - 2'(pop)) < 2'd2);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (i_arm) state_nx = (i_pre_len == '0) ? WAIT_TRIG : PRE;
      PRE:       if (i_en && cnt == pre_len_q - ADDR_WIDTH'(1)) state_nx = WAIT_TRIG;
      WAIT_TRIG: if (trig_fire) state_nx = (pre_len_q == '1) ? READ : POST;
      POST:      if (i_en && cnt == ~pre_len_q - ADDR_WIDTH'(1)) state_nx = READ;
      READ:      if (pop && rd_last) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (i_abort) state_nx = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // The ring is exactly full on entering READ, so the oldest sample
  // (trigger address minus pre_len) is the next write address: ptr doubles as read pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      cnt        <= '0;
      pre_len_q  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arm) begin
            pre_len_q  <= i_pre_len;
            cnt        <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
            triggered  <= 1'b0;
          end
        end
        PRE: begin
          if (i_en) begin
            ptr        <= ptr + ADDR_WIDTH'(1);
            cnt        <= cnt + ADDR_WIDTH'(1);
            prev       <= cur;
            prev_valid <= 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (i_force) force_pend <= 1'b1;
          if (i_en) begin
            ptr        <= ptr + ADDR_WIDTH'(1);
            prev       <= cur;
            prev_valid <= 1'b1;
          end
          if (trig_fire) begin
            triggered  <= 1'b1;
            force_pend <= 1'b0;
            cnt        <= '0;
          end
        end
        POST: begin
          if (i_en) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        READ: begin
          if (issue) ptr <= ptr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
      if (i_abort) begin
        force_pend <= 1'b0;
        triggered  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_issued <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
    end else if (i_abort || state == IDLE) begin
      rd_issued <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
    end else begin
      rd_pend   <= issue;
      pend_last <= issue && (rd_issued[ADDR_WIDTH-1:0] == '1);
      if (issue) rd_issued <= rd_issued + (ADDR_WIDTH+1)'(1);
      if (out_free) begin
        if (sk_valid) begin
          rd_valid <= 1'b1;
          rd_data  <= sk_data;
          rd_last  <= sk_last;
          sk_valid <= rd_pend;
          sk_data  <= ram_q;
          sk_last  <= pend_last;
        end else if (rd_pend) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_last  <= pend_last;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= ram_q;
        sk_last  <= pend_last;
      end
    end
  end

  wave_capture_ram #(
    .WIDTH      (W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (ptr),
    .i_wdata (i_data),
    .i_re    (issue),
    .i_raddr (ptr),
    .o_rdata (ram_q)
  );

  assign o_busy      = (state != IDLE);
  assign o_triggered = triggered;
  assign o_rd_valid  = rd_valid;
  assign o_rd_data   = rd_data;
  assign o_rd_last   = rd_last;

`ifndef SYNTHESIS
  if (LINK != "") begin : g_link
    function automatic string beat_line(input logic [W-1:0] beat);
      string s;
      s = "";
      for (int unsigned c = 0; c < CH; c++) begin
        if (c == 0) s = $sformatf("%0d", $signed(beat[c*DATA_WIDTH +: DATA_WIDTH]));
        else        s = {s, $sformatf(" %0d", $signed(beat[c*DATA_WIDTH +: DATA_WIDTH]))};
      end
      return s;
    endfunction

    always_ff @(posedge i_clk) begin
      if (!i_rst && rd_valid && i_rd_ready) $display("%s", beat_line(rd_data));
    end
  end
`endif

endmodule

// File: tb/tb_wave_capture.sv
// Directed/randomized bench for wave_capture against a sample-list reference model.
module tb_wave_capture;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_rst, i_en, i_arm, i_abort, i_force, i_trig_edge, i_rd_ready;
    logic [0:0]  i_trig_ch;
    logic [47:0] i_data;
    logic [23:0] i_trig_level;
    logic [3:0]  i_pre_len;
    logic        o_busy, o_triggered, o_rd_valid, o_rd_last;
    logic [47:0] o_rd_data;

    int errors = 0;
    int checks = 0;

    wave_capture #(
        .DATA_WIDTH (24),
        .CH         (2),
        .ADDR_WIDTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_data       (i_data),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_force      (i_force),
        .i_trig_ch    (i_trig_ch),
        .i_trig_edge  (i_trig_edge),
        .i_trig_level (i_trig_level),
        .i_pre_len    (i_pre_len),
        .o_busy       (o_busy),
        .o_triggered  (o_triggered),
        .o_rd_valid   (o_rd_valid),
        .i_rd_ready   (i_rd_ready),
        .o_rd_data    (o_rd_data),
        .o_rd_last    (o_rd_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    function automatic logic [47:0] gen(input int mode, input int k);
        logic [23:0] a, b;
        real r;
        case (mode)
            0: begin
                a = 24'(k);
                b = 24'($urandom);
            end
            1: begin
                r = 1000.0 * $sin(2.0 * 3.14159265 * real'(k) / 11.0);
                a = 24'($urandom);
                b = 24'($rtoi(r));
            end
            default: begin
                a = 24'($urandom);
                b = 24'($urandom);
            end
        endcase
        return {b, a};
    endfunction

    function automatic bit crosses(input logic [47:0] p, input logic [47:0] c, input bit tch,
                                   input bit fall, input logic signed [23:0] lv);
        logic signed [23:0] ps, cs;
        ps = tch ? p[47:24] : p[23:0];
        cs = tch ? c[47:24] : c[23:0];
        return fall ? (ps > lv && cs <= lv) : (ps < lv && cs >= lv);
    endfunction

    task automatic feed(input logic [47:0] w);
        i_en   = 1'b1;
        i_data = w;
        tick();
        i_en   = 1'b0;
    endtask

    // Reference: record every fed sample; the trigger index is the first sample at or
    // past the pre window that crosses (or follows a force); expected beats are the
    // DEPTH samples starting pre_len before it.
    task automatic capture(input string tag, input int pre, input bit fall, input int level,
                           input bit tch, input int mode, input int force_at, input bit poke,
                           input int ready_mode);
        logic [47:0] fed[$];
        logic [47:0] w, held_data;
        int  trig, k, cyc, nb, first_cyc, last_cyc;
        bit  rdy, held, held_last, timed_out;
        trig = -1; k = 0; nb = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        held = 1'b0; held_last = 1'b0; held_data = '0; timed_out = 1'b0;

        i_pre_len    = 4'(pre);
        i_trig_edge  = fall;
        i_trig_level = 24'(level);
        i_trig_ch    = tch;
        i_arm        = 1'b1;
        tick();
        i_arm = 1'b0;
        check({tag, ".arm_busy"}, 64'(o_busy), 64'd1);
        check({tag, ".arm_trig"}, 64'(o_triggered), 64'd0);

        while (trig < 0 || k < trig + DEPTH - pre) begin
            if (k >= 300) begin
                fail_now({tag, ".model_trigger"});
                timed_out = 1'b1;
                break;
            end
            repeat ($urandom_range(0, 1)) tick();
            if (k == force_at) begin
                i_force = 1'b1;
                if (poke) begin
                    i_arm     = 1'b1;
                    i_pre_len = 4'(pre + 5);
                end
                tick();
                i_force   = 1'b0;
                i_arm     = 1'b0;
                i_pre_len = 4'(pre);
                if (trig < 0 && k >= pre) trig = k;
            end
            w = gen(mode, k);
            feed(w);
            fed.push_back(w);
            if (trig < 0 && k >= pre && k >= 1 && crosses(fed[k-1], w, tch, fall, 24'(level)))
                trig = k;
            k++;
        end

        if (!timed_out) begin
            check({tag, ".post_trig"}, 64'(o_triggered), 64'd1);
            while (nb < DEPTH && cyc < 200) begin
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = 1'(($urandom % 2));
                endcase
                i_rd_ready = rdy;
                i_en       = 1'($urandom % 2);
                i_data     = {24'($urandom), 24'($urandom)};
                if (held) begin
                    check($sformatf("%s.hold_valid%0d", tag, nb), 64'(o_rd_valid), 64'd1);
                    check($sformatf("%s.hold_data%0d", tag, nb), 64'(o_rd_data), 64'(held_data));
                    check($sformatf("%s.hold_last%0d", tag, nb), 64'(o_rd_last), 64'(held_last));
                end
                held = 1'b0;
                if (o_rd_valid) begin
                    if (rdy) begin
                        check($sformatf("%s.beat%0d", tag, nb), 64'(o_rd_data), 64'(fed[trig - pre + nb]));
                        check($sformatf("%s.last%0d", tag, nb), 64'(o_rd_last), 64'(nb == DEPTH - 1));
                        check($sformatf("%s.trig%0d", tag, nb), 64'(o_triggered), 64'd1);
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                        nb++;
                    end else begin
                        held      = 1'b1;
                        held_data = o_rd_data;
                        held_last = o_rd_last;
                    end
                end
                tick();
                cyc++;
            end
            i_rd_ready = 1'b0;
            i_en       = 1'b0;
            check({tag, ".beat_count"}, 64'(nb), 64'(DEPTH));
            check({tag, ".idle_busy"}, 64'(o_busy), 64'd0);
            check({tag, ".idle_valid"}, 64'(o_rd_valid), 64'd0);
            if (ready_mode == 0) begin
                check({tag, ".first_latency_ok"}, 64'(first_cyc >= 0 && first_cyc <= 2), 64'd1);
                check({tag, ".full_rate_span"}, 64'(last_cyc - first_cyc), 64'(DEPTH - 1));
            end
        end

        if (o_busy) begin
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_arm = 1'b0; i_abort = 1'b0; i_force = 1'b0;
        i_trig_edge = 1'b0; i_rd_ready = 1'b0; i_trig_ch = '0; i_data = '0;
        i_trig_level = '0; i_pre_len = '0;
        repeat (3) tick();
        check("rst.busy", 64'(o_busy), 64'd0);
        check("rst.triggered", 64'(o_triggered), 64'd0);
        check("rst.valid", 64'(o_rd_valid), 64'd0);
        check("rst.last", 64'(o_rd_last), 64'd0);
        check("rst.data", 64'(o_rd_data), 64'd0);
        i_rst = 1'b0;
        tick();

        capture("ramp_rise", 4, 1'b0, 20, 1'b0, 0, -1, 1'b0, 0);
        capture("sine_fall", 5, 1'b1, 0, 1'b1, 1, -1, 1'b0, 2);
        capture("force_pre0", 0, 1'b0, 8388607, 1'b0, 0, 3, 1'b0, 0);
        capture("stall_1001", 7, 1'b0, 0, 1'b0, 2, -1, 1'b0, 1);

        // Abort on the same cycle as the triggering sample.
        i_pre_len = 4'd2; i_trig_edge = 1'b0; i_trig_level = 24'd5; i_trig_ch = 1'b0;
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        for (int k = 0; k < 5; k++) feed(gen(0, k));
        check("abort.pre_busy", 64'(o_busy), 64'd1);
        check("abort.pre_trig", 64'(o_triggered), 64'd0);
        i_abort = 1'b1;
        i_arm   = 1'b1;
        feed(gen(0, 5));
        i_abort = 1'b0;
        i_arm   = 1'b0;
        check("abort.busy", 64'(o_busy), 64'd0);
        check("abort.trig", 64'(o_triggered), 64'd0);
        check("abort.valid", 64'(o_rd_valid), 64'd0);
        capture("after_abort", 3, 1'b1, 0, 1'b1, 2, -1, 1'b0, 2);

        // Reset while in POST.
        i_pre_len = 4'd4; i_trig_edge = 1'b0; i_trig_level = 24'd20; i_trig_ch = 1'b0;
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        for (int k = 0; k < 25; k++) feed(gen(0, k));
        check("rstmid.pre_trig", 64'(o_triggered), 64'd1);
        check("rstmid.pre_busy", 64'(o_busy), 64'd1);
        i_rst = 1'b1;
        #1;
        check("rstmid.busy", 64'(o_busy), 64'd0);
        check("rstmid.trig", 64'(o_triggered), 64'd0);
        check("rstmid.valid", 64'(o_rd_valid), 64'd0);
        check("rstmid.last", 64'(o_rd_last), 64'd0);
        check("rstmid.data", 64'(o_rd_data), 64'd0);
        tick();
        i_rst = 1'b0;
        tick();
        capture("after_rst_poke", 4, 1'b0, 20, 1'b0, 0, 2, 1'b1, 0);

        capture("pre_max", 15, 1'b0, 0, 1'b0, 2, -1, 1'b0, 2);
        capture("rand_pre", int'($urandom_range(1, 14)), 1'b1, 0, 1'b0, 2, -1, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
